// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - architectural ALU flags and conditional branch resolver
module flag_branch_unit #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             zr_in,
    input  logic             neg_in,
    input  logic             ov_in,
    input  logic [2:0]       flag_we,
    input  logic             flush,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [PC_W-1:0]  pc_plus1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_taken,
    output logic [PC_W-1:0]  br_target,
    output logic [2:0]       flags_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] C_NEQ    = 3'b000;
    localparam logic [2:0] C_EQ     = 3'b001;
    localparam logic [2:0] C_GT     = 3'b010;
    localparam logic [2:0] C_LT     = 3'b011;
    localparam logic [2:0] C_GTE    = 3'b100;
    localparam logic [2:0] C_LTE    = 3'b101;
    localparam logic [2:0] C_OVFL   = 3'b110;

    state_t            state;
    logic [2:0]        flags_fwd;
    logic [2:0]        snap_cond;
    logic [OFF_W-1:0]  snap_off;
    logic [PC_W-1:0]   snap_pc;
    logic [2:0]        snap_flags;
    logic              eval_taken;
    logic [PC_W-1:0]   eval_target;
    logic [PC_W-1:0]   off_ext;

    // A flag written in the same cycle as a branch accept is visible to that branch
    assign flags_fwd = (flag_we & {ov_in, neg_in, zr_in}) | (~flag_we & flags_q);

    assign br_ready = (state == IDLE);

    // Architectural flags: per-bit write enables, independent of the branch FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_fwd;
        end
    end

    // Condition evaluation and target computation from the captured snapshot
    always_comb begin
        eval_taken = 1'b0;
        case (snap_cond)
            C_NEQ:   eval_taken = ~snap_flags[0];
            C_EQ:    eval_taken = snap_flags[0];
            C_GT:    eval_taken = ~snap_flags[0] & ~snap_flags[1];
            C_LT:    eval_taken = snap_flags[1];
            C_GTE:   eval_taken = snap_flags[0] | ~snap_flags[1];
            C_LTE:   eval_taken = snap_flags[0] | snap_flags[1];
            C_OVFL:  eval_taken = snap_flags[2];
            default: eval_taken = 1'b1;
        endcase
        off_ext     = {{(PC_W-OFF_W){snap_off[OFF_W-1]}}, snap_off};
        eval_target = eval_taken ? (snap_pc + off_ext) : snap_pc;
    end

    // Request/response handshake; flush aborts from any state and wins over accept/release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            br_taken   <= 1'b0;
            br_target  <= '0;
            snap_cond  <= 3'b000;
            snap_off   <= '0;
            snap_pc    <= '0;
            snap_flags <= 3'b000;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid) begin
                        snap_cond  <= br_cond;
                        snap_off   <= br_offset;
                        snap_pc    <= pc_plus1;
                        snap_flags <= flags_fwd;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    br_taken  <= eval_taken;
                    br_target <= eval_target;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed scoreboard bench for flag_branch_unit
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        zr_in, neg_in, ov_in;
    logic [2:0]  flag_we;
    logic        flush;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [8:0]  br_offset;
    logic [15:0] pc_plus1;
    logic        out_valid;
    logic        out_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic [2:0]  flags_q;

    typedef struct packed {
        logic        taken;
        logic [15:0] target;
    } result_t;

    result_t     sb_q[$];
    result_t     last_res;
    logic [2:0]  m_flags;
    int          tests = 0;
    int          fails = 0;

    flag_branch_unit #(.PC_W(16), .OFF_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .zr_in     (zr_in),
        .neg_in    (neg_in),
        .ov_in     (ov_in),
        .flag_we   (flag_we),
        .flush     (flush),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_offset (br_offset),
        .pc_plus1  (pc_plus1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    // Reference flag register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_flags <= 3'b000;
        else        m_flags <= (flag_we & {ov_in, neg_in, zr_in}) | (~flag_we & m_flags);
    end

    function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
        logic z, n, v;
        z = f[0]; n = f[1]; v = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request (optionally with a same-cycle flag write) and push its expected result
    task automatic accept(input logic [2:0] c, input logic [8:0] off, input logic [15:0] pc,
                          input logic [2:0] fwe, input logic [2:0] fin);
        logic [2:0] fwd;
        result_t    r;
        @(negedge clk);
        chk("ready_before_accept", 32'(br_ready), 32'd1);
        br_valid  = 1'b1;
        br_cond   = c;
        br_offset = off;
        pc_plus1  = pc;
        flag_we   = fwe;
        {ov_in, neg_in, zr_in} = fin;
        fwd = (fwe & fin) | (~fwe & m_flags);
        r.taken  = cond_eval(c, fwd);
        r.target = r.taken ? pc + {{7{off[8]}}, off} : pc;
        sb_q.push_back(r);
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        flag_we  = 3'b000;
    endtask

    // Wait for out_valid, compare with scoreboard head, optionally release via out_ready
    task automatic get_result(input string tag, input bit check_lat, input bit release_it);
        int      n;
        result_t r;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        if (check_lat) chk({tag, "_latency"}, 32'(n), 32'd2);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        r = sb_q.pop_front();
        last_res = r;
        chk({tag, "_taken"}, 32'(br_taken), 32'(r.taken));
        chk({tag, "_target"}, 32'(br_target), 32'(r.target));
        chk({tag, "_busy"}, 32'(br_ready), 32'd0);
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_released"}, 32'(out_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(br_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; zr_in = 0; neg_in = 0; ov_in = 0; flag_we = 3'b000;
        flush = 0; br_valid = 0; br_cond = 0; br_offset = 0; pc_plus1 = 0; out_ready = 0;
        last_res = '0;
        #12;
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_taken", 32'(br_taken), 32'd0);
        chk("rst_target", 32'(br_target), 32'd0);
        chk("rst_ready", 32'(br_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag register writes
        @(negedge clk);
        flag_we = 3'b111; {ov_in, neg_in, zr_in} = 3'b001;
        @(negedge clk);
        chk("flags_write_all", 32'(flags_q), 32'h1);
        flag_we = 3'b001; {ov_in, neg_in, zr_in} = 3'b110;
        @(negedge clk);
        chk("flags_write_zr_only", 32'(flags_q), 32'h0);
        flag_we = 3'b000;

        // Basic NEQ taken with negative offset, latency and hold
        accept(3'b000, 9'h1FE, 16'h0010, 3'b000, 3'b000);
        chk("eval_not_valid", 32'(out_valid), 32'd0);
        get_result("neq_back", 1'b1, 1'b0);
        chk("neq_fixed_target", 32'(br_target), 32'h000E);
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_target", 32'(br_target), 32'h000E);
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(br_ready), 32'd1);

        // Forwarded flag write, then a write during EVAL that must not leak in
        accept(3'b001, 9'h004, 16'h0100, 3'b111, 3'b001);
        flag_we = 3'b001; zr_in = 1'b0;
        @(posedge clk); #1; flag_we = 3'b000;
        get_result("fwd_eq", 1'b0, 1'b1);
        chk("fwd_eq_taken", 32'(last_res.taken), 32'd1);
        chk("flags_after_clear", 32'(flags_q), 32'h0);

        // Wrap-around target and not-taken overflow
        accept(3'b111, 9'h002, 16'hFFFF, 3'b000, 3'b000);
        get_result("wrap", 1'b1, 1'b1);
        chk("wrap_target", 32'(last_res.target), 32'h0001);
        accept(3'b110, 9'h010, 16'h2000, 3'b000, 3'b000);
        get_result("ovfl_nt", 1'b1, 1'b1);
        chk("ovfl_nt_target", 32'(last_res.target), 32'h2000);

        // Sweep every condition over every flag combination
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                accept(3'(c), 9'(c * 3 + 1), 16'(16'h0400 + f * 16), 3'b111, 3'(f));
                get_result($sformatf("sweep_c%0d_f%0d", c, f), 1'b1, 1'b1);
            end
        end
        chk("sweep_gte_zn", 32'(cond_eval(3'd4, 3'b011)), 32'd1);

        // flush during EVAL
        accept(3'b111, 9'h005, 16'h3000, 3'b000, 3'b000);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        void'(sb_q.pop_front());
        @(negedge clk);
        chk("flush_eval_valid", 32'(out_valid), 32'd0);
        chk("flush_eval_ready", 32'(br_ready), 32'd1);
        chk("flush_eval_keep_taken", 32'(br_taken), 32'(last_res.taken));
        chk("flush_eval_keep_target", 32'(br_target), 32'(last_res.target));
        chk("flush_eval_flags", 32'(flags_q), 32'(m_flags));
        @(negedge clk);
        chk("flush_eval_no_late_valid", 32'(out_valid), 32'd0);

        // flush during RESP with out_ready and a dropped request
        accept(3'b111, 9'h0F0, 16'h1000, 3'b000, 3'b000);
        get_result("flush_resp", 1'b1, 1'b0);
        flush = 1'b1; out_ready = 1'b1; br_valid = 1'b1; br_cond = 3'b111;
        @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0; br_valid = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", 32'(out_valid), 32'd0);
        chk("flush_resp_ready", 32'(br_ready), 32'd1);
        chk("flush_resp_keep_target", 32'(br_target), 32'h10F0);
        chk("flush_resp_flags", 32'(flags_q), 32'(m_flags));
        @(negedge clk); @(negedge clk);
        chk("flush_resp_dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset while in RESP
        accept(3'b111, 9'h005, 16'h1234, 3'b111, 3'b101);
        get_result("rst_resp", 1'b1, 1'b0);
        chk("rst_resp_target_pre", 32'(last_res.target), 32'h1239);
        chk("rst_resp_flags_pre", 32'(flags_q), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_taken", 32'(br_taken), 32'd0);
        chk("async_rst_target", 32'(br_target), 32'd0);
        chk("async_rst_flags", 32'(flags_q), 32'd0);
        chk("async_rst_ready", 32'(br_ready), 32'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
